// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-cycle execute ALU: operation codes, FSM states, shift amount width.
package alu_seq_pkg;

  localparam int OP_W    = 5;
  localparam int SHAMT_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 5'b00000,
    OP_OR    = 5'b00001,
    OP_ADD   = 5'b00010,
    OP_XOR   = 5'b00011,
    OP_SRL   = 5'b00100,
    OP_SLL   = 5'b00101,
    OP_SUB   = 5'b00110,
    OP_SRA   = 5'b00111,
    OP_BEQ   = 5'b01000,
    OP_BNE   = 5'b01001,
    OP_BLT   = 5'b01010,
    OP_BGE   = 5'b01011,
    OP_BLTU  = 5'b01100,
    OP_BGEU  = 5'b01101,
    OP_SLT   = 5'b10001,
    OP_SLTU  = 5'b10010,
    OP_LDST  = 5'b10011,
    OP_JAL   = 5'b10100,
    OP_JALR  = 5'b10101,
    OP_LUI   = 5'b10110,
    OP_AUIPC = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic op_is_shift(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation request and result return handshakes between the ALU and its neighbours.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_W-1:0]       operation;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  branch_taken;

  modport master (
    output in_valid, operation, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, branch_taken
  );

  modport slave (
    input  in_valid, operation, src_a, src_b, out_ready,
    output in_ready, out_valid, result, branch_taken
  );
endinterface

// File: rtl/alu_seq_shift_step.sv
// One iteration of the iterative shifter: acc shifted by k, left or right, with an explicit fill bit.
module alu_seq_shift_step
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic [SHAMT_W-1:0]    i_k,
  input  logic                  i_left,
  input  logic                  i_fill,
  output logic [DATA_WIDTH-1:0] o_acc
);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  logic [DATA_WIDTH-1:0] w_fill_mask;

  // Vacated upper bits on a right shift; set only for SRA of a negative operand.
  assign w_fill_mask = i_fill ? ~(ONES >> i_k) : '0;

  always_comb begin
    if (i_left) begin
      o_acc = i_acc << i_k;
    end else begin
      o_acc = (i_acc >> i_k) | w_fill_mask;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute ALU: one-cycle ops, iterative shifts, valid/ready in and out.
// Define ALU_SEQ_ILLEGAL_OP_EN to add the illegal_op flag output.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,  // fixed at 32: shift amount is src_b[4:0]
  parameter int SHIFT_STEP = 1    // 1, 2, 4 or 8
) (
  input  logic      clk,
  input  logic      reset_n,
  alu_seq_if.slave  bus
`ifdef ALU_SEQ_ILLEGAL_OP_EN
  ,
  output logic      illegal_op
`endif
);
  localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

  state_e                r_state;
  state_e                w_state_next;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [SHAMT_W-1:0]    r_rem;
  logic                  r_left;
  logic                  r_fill;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_taken;

  alu_op_e               w_op;
  logic [SHAMT_W-1:0]    w_shamt;
  logic                  w_is_shift;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_taken;
  logic [SHAMT_W-1:0]    w_k;
  logic [SHAMT_W-1:0]    w_rem_next;
  logic [DATA_WIDTH-1:0] w_shifted;

`ifdef ALU_SEQ_ILLEGAL_OP_EN
  logic                  r_illegal;
  logic                  w_illegal;
  assign illegal_op = r_illegal;
`endif

  assign w_op       = alu_op_e'(bus.operation);
  assign w_shamt    = bus.src_b[SHAMT_W-1:0];
  assign w_is_shift = op_is_shift(bus.operation);
  assign w_accept   = (r_state == IDLE) && bus.in_valid;

  always_comb begin
    w_alu_result = '0;
    w_taken      = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    w_illegal    = 1'b0;
`endif
    case (w_op)
      OP_AND:   w_alu_result = bus.src_a & bus.src_b;
      OP_OR:    w_alu_result = bus.src_a | bus.src_b;
      OP_XOR:   w_alu_result = bus.src_a ^ bus.src_b;
      OP_ADD,
      OP_LDST,
      OP_AUIPC: w_alu_result = bus.src_a + bus.src_b;
      OP_SUB:   w_alu_result = bus.src_a - bus.src_b;
      // Only reached with shamt == 0; non-zero shifts go through the SHIFT state.
      OP_SLL,
      OP_SRL,
      OP_SRA:   w_alu_result = bus.src_a;
      OP_SLT:   w_alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
      OP_SLTU:  w_alu_result = {{(DATA_WIDTH-1){1'b0}}, bus.src_a < bus.src_b};
      OP_JAL,
      OP_JALR:  w_alu_result = bus.src_a + DATA_WIDTH'(4);
      OP_LUI:   w_alu_result = bus.src_b;
      OP_BEQ:   w_taken = (bus.src_a == bus.src_b);
      OP_BNE:   w_taken = (bus.src_a != bus.src_b);
      OP_BLT:   w_taken = ($signed(bus.src_a) <  $signed(bus.src_b));
      OP_BGE:   w_taken = ($signed(bus.src_a) >= $signed(bus.src_b));
      OP_BLTU:  w_taken = (bus.src_a <  bus.src_b);
      OP_BGEU:  w_taken = (bus.src_a >= bus.src_b);
      default: begin
`ifdef ALU_SEQ_ILLEGAL_OP_EN
        w_illegal = 1'b1;
`endif
      end
    endcase
    if (w_taken) begin
      w_alu_result = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign w_k        = (r_rem > STEP) ? STEP : r_rem;
  assign w_rem_next = r_rem - w_k;

  alu_seq_shift_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift_step (
    .i_acc  (r_acc),
    .i_k    (w_k),
    .i_left (r_left),
    .i_fill (r_fill),
    .o_acc  (w_shifted)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = (w_is_shift && (w_shamt != '0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (w_rem_next == '0) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_rem    <= '0;
      r_left   <= 1'b0;
      r_fill   <= 1'b0;
      r_result <= '0;
      r_taken  <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
      r_illegal <= 1'b0;
`endif
    end else if (w_accept) begin
`ifdef ALU_SEQ_ILLEGAL_OP_EN
      r_illegal <= w_illegal;
`endif
      if (w_is_shift && (w_shamt != '0)) begin
        r_acc  <= bus.src_a;
        r_rem  <= w_shamt;
        r_left <= (w_op == OP_SLL);
        r_fill <= (w_op == OP_SRA) && bus.src_a[DATA_WIDTH-1];
      end else begin
        r_result <= w_alu_result;
        r_taken  <= w_taken;
      end
    end else if (r_state == SHIFT) begin
      r_acc <= w_shifted;
      r_rem <= w_rem_next;
      if (w_rem_next == '0) begin
        r_result <= w_shifted;
        r_taken  <= 1'b0;
      end
    end
  end

  assign bus.result       = r_result;
  assign bus.branch_taken = r_taken;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (SHIFT_STEP=1); expected values are hand-computed.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_bad;

  alu_seq_if #(.DATA_WIDTH(32)) bus ();

`ifdef ALU_SEQ_ILLEGAL_OP_EN
  logic illegal_op;
`endif

  alu_seq #(
    .DATA_WIDTH (32),
    .SHIFT_STEP (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus)
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1 and check latency, result, flag and return to IDLE.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input logic exp_t,
                        input int exp_lat, input logic exp_ill);
    int lat;
    int busy_hi;
    bus.operation = op;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.operation = 5'h1f;
    bus.src_a     = ~a;
    bus.src_b     = ~b;
    lat = 0;
    busy_hi = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) busy_hi++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".res"}, bus.result, exp_r);
    chk({tag, ".tkn"}, 32'(bus.branch_taken), 32'(exp_t));
    chk({tag, ".busy"}, 32'(busy_hi), 32'd0);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    chk({tag, ".ill"}, 32'(illegal_op), 32'(exp_ill));
`endif
    $display("op %s: code=%b a=%h b=%h result=%h taken=%0d lat=%0d ill_exp=%0d",
             tag, op, a, b, bus.result, bus.branch_taken, lat, exp_ill);
    @(posedge clk); #1;
    chk({tag, ".idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.operation = '0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.taken", 32'(bus.branch_taken), 32'd0);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    chk("rst.ill", 32'(illegal_op), 32'd0);
`endif
    $display("reset: in_ready=%0d out_valid=%0d result=%h", bus.in_ready, bus.out_valid, bus.result);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("add",   5'b00010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0,  1'b0);
    run_op("sub",   5'b00110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 0,  1'b0);
    run_op("and",   5'b00000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 0,  1'b0);
    run_op("or",    5'b00001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 0,  1'b0);
    run_op("xor",   5'b00011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 0,  1'b0);
    run_op("sra31", 5'b00111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 31, 1'b0);
    run_op("srl31", 5'b00100, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 31, 1'b0);
    run_op("sll0",  5'b00101, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0, 0,  1'b0);
    run_op("sll4",  5'b00101, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 4,  1'b0);
    run_op("sra4p", 5'b00111, 32'h7000_0000, 32'h0000_0004, 32'h0700_0000, 1'b0, 4,  1'b0);
    run_op("slt",   5'b10001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 0,  1'b0);
    run_op("sltu",  5'b10010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0,  1'b0);
    run_op("blt",   5'b01010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 0,  1'b0);
    run_op("bltu",  5'b01100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0,  1'b0);
    run_op("bgeu",  5'b01101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 0,  1'b0);
    run_op("beq",   5'b01000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0001, 1'b1, 0,  1'b0);
    run_op("bne",   5'b01001, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b0, 0,  1'b0);
    run_op("ldst",  5'b10011, 32'h0000_0008, 32'hFFFF_FFFC, 32'h0000_0004, 1'b0, 0,  1'b0);
    run_op("jal",   5'b10100, 32'h0000_0100, 32'h0000_0FFF, 32'h0000_0104, 1'b0, 0,  1'b0);
    run_op("auipc", 5'b10111, 32'h0000_1000, 32'h0000_0020, 32'h0000_1020, 1'b0, 0,  1'b0);
    run_op("illeg", 5'b11111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 0,  1'b1);

    // Backpressure: result held while out_ready=0 and new requests ignored.
    bus.operation = 5'b10110;
    bus.src_a     = 32'h0000_0000;
    bus.src_b     = 32'hABCD_E000;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.operation = 5'b00010;
    bus.src_a     = 32'h0000_0001;
    bus.src_b     = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", 32'(bus.out_valid), 32'd1);
      chk("bp.res", bus.result, 32'hABCD_E000);
      chk("bp.rdy", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.idle", 32'(bus.in_ready), 32'd1);
    chk("bp.ovld", 32'(bus.out_valid), 32'd0);
    $display("op lui-backpressure: result=%h in_ready=%0d", bus.result, bus.in_ready);

    // Reset in the middle of a 20-bit SLL.
    bus.operation = 5'b00101;
    bus.src_a     = 32'h0000_0001;
    bus.src_b     = 32'h0000_0014;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid.busy", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid.in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid.out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid.result", bus.result, 32'd0);
    $display("op sll-reset: in_ready=%0d out_valid=%0d result=%h", bus.in_ready, bus.out_valid, bus.result);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mid.stay", 32'(bus.out_valid), 32'd0);

    run_op("lui",   5'b10110, 32'h0000_0000, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 0,  1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
